uart_tx: RTL and testbench

Asynchronous serial transmitter, the sending counterpart of the team's `uart_rx` unit. Accepts one byte per `start`/`ready` handshake and shifts it out on `tx` as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) at a rate fixed by the `BAUD` divisor. It sits between user logic, such as an echo or a string generator, and the FPGA's TX pin, and shares the baud divisor constants with the receiver.

---
 rtl/uart_tx_pkg.sv | 35 +++
 rtl/baudgen_tx.sv | 32 +++
 rtl/uart_tx.sv | 74 +++++++
 tb/tb_uart_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the serial transmitter: baud divisor constants
// (cycles per bit at a 12 MHz system clock, shared with the receiver),
// frame length and the frame builder.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 8E1).
package uart_tx_pkg;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Frame as it sits in the shift register: bit 0 goes out first.
    function automatic frame_t build_frame(input logic [7:0] byte_in);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^byte_in, byte_in, 1'b0};
`else
        return {1'b1, byte_in, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/baudgen_tx.sv
// Bit-rate tick generator for the transmitter. The tick lands on the last
// cycle of each bit period (the receiver's generator ticks at mid-bit).
// Optional feature macro: none here (UART_TX_PARITY_EN lives in the package).
module baudgen_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic clk,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int CW = (BAUD > 1) ? $clog2(BAUD) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD - 1);

    logic [CW-1:0] count;

    // Count 0..BAUD-1 while enabled, hold at zero while disabled.
    always_ff @(posedge clk) begin
        if (!clk_ena) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign clk_out = clk_ena && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: one byte per start/ready handshake, sent LSB first
// as start bit, 8 data bits, optional even parity, stop bit.
// Optional feature macro: UART_TX_PARITY_EN (8E1 instead of 8N1).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        TRANS = 1'b1
    } state_t;

    state_t     state;
    frame_t     shift_reg;
    logic [3:0] bit_cnt;
    logic       baud_ena;
    logic       baud_tick;

    // The divider runs only during a frame, so every frame starts on a fresh count.
    assign baud_ena = (state == TRANS) && !rst;

    baudgen_tx #(
        .BAUD (BAUD)
    ) u_baudgen (
        .clk     (clk),
        .clk_ena (baud_ena),
        .clk_out (baud_tick)
    );

    // Control FSM; tx and ready are registered from the pre-edge state so they trail acceptance by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '1;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            ready     <= 1'b1;
        end else begin
            tx    <= (state == TRANS) ? shift_reg[0] : 1'b1;
            ready <= (state == IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= build_frame(data);
                        bit_cnt   <= '0;
                        state     <= TRANS;
                    end
                end
                TRANS: begin
                    if (baud_tick) begin
                        shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at BAUD = 4. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       ready;

    int check_count = 0;
    int fail_count  = 0;

    uart_tx #(
        .BAUD (BAUD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .tx    (tx),
        .ready (ready)
    );

    always #5 clk = ~clk;

    // Expected line level for bit position i of the frame carrying byte d.
    function automatic logic expBit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        check_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_tx_%0d", name, c), tx, 1'b1);
            checkOutput($sformatf("%s_ready_%0d", name, c), ready, 1'b1);
        end
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_ready_wait"}, ready, 1'b1);
    endtask

    // Present a byte for one edge (the acceptance edge), then scramble data.
    task automatic applyStimulus(input logic [7:0] d);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom);
    endtask

    // Called at the negedge right after the acceptance edge; walks the whole frame.
    task automatic checkFrame(input logic [7:0] d, input string name, input bit disturb);
        for (int c = 1; c <= FRAME_LEN * BAUD; c++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_tx_c%0d", name, c), tx, expBit(d, (c - 1) / BAUD));
            checkOutput($sformatf("%s_ready_c%0d", name, c), ready, 1'b0);
            if (disturb && c == 12) begin
                start = 1'b1;
                data  = 8'hFF;
            end
            if (disturb && c == 20) start = 1'b0;
        end
        @(negedge clk);
        checkOutput({name, "_end_tx"}, tx, 1'b1);
        checkOutput({name, "_end_ready"}, ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] rnd;
        rst   = 1'b1;
        start = 1'b0;
        data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_ready", ready, 1'b1);
        rst = 1'b0;
        checkIdle("idle", 50);

        // Alternating pattern.
        waitReady("f55");
        applyStimulus(8'h55);
        checkFrame(8'h55, "f55", 1'b0);

        // start and data disturbed mid-frame; no second frame may follow.
        waitReady("fA3");
        applyStimulus(8'hA3);
        checkFrame(8'hA3, "fA3", 1'b1);
        checkIdle("fA3_after", 15);

        // start held high: back-to-back frames with a single idle cycle.
        waitReady("b2b");
        start = 1'b1;
        data  = 8'h00;
        @(negedge clk);
        checkFrame(8'h00, "b2b1", 1'b0);
        start = 1'b0;
        checkFrame(8'h00, "b2b2", 1'b0);
        checkIdle("b2b_after", 10);

        // Reset during bit 3 abandons the frame.
        waitReady("rst0F");
        applyStimulus(8'h0F);
        for (int c = 1; c <= 3 * BAUD + 1; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rst0F_tx_c%0d", c), tx, expBit(8'h0F, (c - 1) / BAUD));
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tx", tx, 1'b1);
        checkOutput("midrst_ready", ready, 1'b1);
        rst = 1'b0;
        checkIdle("midrst_after", 10);
        waitReady("f0F");
        applyStimulus(8'h0F);
        checkFrame(8'h0F, "f0F", 1'b0);

        // Byte with odd population count (parity bit 1 when enabled).
        waitReady("f07");
        applyStimulus(8'h07);
        checkFrame(8'h07, "f07", 1'b0);

        // Random bytes.
        for (int n = 0; n < 4; n++) begin
            rnd = 8'($urandom);
            waitReady($sformatf("rnd%0d", n));
            applyStimulus(rnd);
            checkFrame(rnd, $sformatf("rnd%0d_%02h", n, rnd), 1'b0);
        end
        checkIdle("final", 5);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
